// File: rtl/accel_sequencer.sv
// accel_sequencer: steps one accelerator unit through a forward pass and an SGD update,
// streaming chunks from local SRAMs and writing updated weights back.
module accel_sequencer #(
  parameter int INPUT_BITWIDTH = 8,
  parameter int BITWIDTH = 16,
  parameter int SIZE = 4,
  parameter int NUM_CYCLE = 4,
  parameter int LOG_NUM_CYCLE = 2,
  parameter int IP_LAT = 2,
  parameter int COMB_LAT = 1,
  parameter int SGD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [INPUT_BITWIDTH-1:0] bias_in,
  input  logic [INPUT_BITWIDTH-1:0] rate_in,
  input  logic [INPUT_BITWIDTH-1:0] mu_in,
  output logic busy,
  output logic done,
  output logic x_rd_en,
  output logic [LOG_NUM_CYCLE-1:0] x_rd_addr,
  input  logic [INPUT_BITWIDTH*SIZE-1:0] x_rd_data,
  output logic w_rd_en,
  output logic [LOG_NUM_CYCLE-1:0] w_rd_addr,
  input  logic [BITWIDTH*SIZE-1:0] w_rd_data,
  output logic w_wr_en,
  output logic [LOG_NUM_CYCLE-1:0] w_wr_addr,
  output logic [BITWIDTH*SIZE-1:0] w_wr_data,
  output logic [INPUT_BITWIDTH*SIZE-1:0] acc_x,
  output logic [INPUT_BITWIDTH*SIZE-1:0] acc_sgd_x,
  output logic [BITWIDTH*SIZE-1:0] acc_w,
  output logic [BITWIDTH*SIZE-1:0] acc_sgd_w,
  output logic [INPUT_BITWIDTH-1:0] acc_bias,
  output logic [INPUT_BITWIDTH-1:0] acc_rate,
  output logic [INPUT_BITWIDTH-1:0] acc_mu,
  output logic acc_sel,
  output logic acc_comb_valid,
  input  logic [BITWIDTH*SIZE-1:0] acc_data_out_r
);
  localparam int AW = LOG_NUM_CYCLE;
  localparam int CW = $clog2(IP_LAT + COMB_LAT + SGD_LAT + 2) + 1;
  localparam logic [AW-1:0] LAST = AW'(NUM_CYCLE - 1);

  typedef enum logic [2:0] {IDLE, FWD, WAIT_IP, WAIT_GRAD, UPD, DRAIN} state_t;
  state_t state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic fwd_vld;
  // index 0 is the SGD presentation stage; index SGD_LAT is the write stage
  logic [SGD_LAT:0] wv;
  logic [SGD_LAT:0][AW-1:0] wa;

  always_comb begin
    state_n = state;
    addr_n = '0;
    wcnt_n = '0;
    case (state)
      IDLE: if (start) state_n = FWD;
      FWD: if (addr == LAST) state_n = IP_LAT > 0 ? WAIT_IP : COMB_LAT > 1 ? WAIT_GRAD : UPD;
           else addr_n = addr + AW'(1);
      WAIT_IP: if (wcnt == CW'(IP_LAT - 1)) state_n = COMB_LAT > 1 ? WAIT_GRAD : UPD;
               else wcnt_n = wcnt + CW'(1);
      WAIT_GRAD: if (wcnt == CW'(COMB_LAT - 2)) state_n = UPD;
                 else wcnt_n = wcnt + CW'(1);
      UPD: if (addr == LAST) state_n = DRAIN;
           else addr_n = addr + AW'(1);
      DRAIN: if (wcnt == CW'(SGD_LAT)) state_n = IDLE;
             else wcnt_n = wcnt + CW'(1);
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      wcnt <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      wcnt <= wcnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      x_rd_en <= 1'b0;
      acc_sel <= 1'b0;
      acc_comb_valid <= 1'b0;
      fwd_vld <= 1'b0;
      wv <= '0;
      wa <= '0;
      acc_bias <= '0;
      acc_rate <= '0;
      acc_mu <= '0;
    end else begin
      busy <= state_n != IDLE;
      done <= state == DRAIN && state_n == IDLE;
      x_rd_en <= state_n == FWD || state_n == UPD;
      acc_sel <= state == FWD && addr != '0;
      acc_comb_valid <= (state == FWD && addr == LAST && IP_LAT == 0) ||
                        (state == WAIT_IP && wcnt == CW'(IP_LAT - 1));
      fwd_vld <= state == FWD;
      wv[0] <= state == UPD;
      wa[0] <= addr;
      for (int i = 1; i <= SGD_LAT; i++) begin
        wv[i] <= wv[i-1];
        wa[i] <= wa[i-1];
      end
      if (state == IDLE && start) begin
        acc_bias <= bias_in;
        acc_rate <= rate_in;
        acc_mu <= mu_in;
      end
    end
  end

  assign w_rd_en = x_rd_en;
  assign x_rd_addr = addr;
  assign w_rd_addr = addr;
  assign acc_x = fwd_vld ? x_rd_data : '0;
  assign acc_w = fwd_vld ? w_rd_data : '0;
  assign acc_sgd_x = wv[0] ? x_rd_data : '0;
  assign acc_sgd_w = wv[0] ? w_rd_data : '0;
  assign w_wr_en = wv[SGD_LAT];
  assign w_wr_addr = wa[SGD_LAT];
  assign w_wr_data = w_wr_en ? acc_data_out_r : '0;
endmodule
